// File: rtl/lcd_char_driver_if.sv
// Signals shared by the LCD character driver, its upstream character source and the LCD pins.
// The master side is the driver; the slave side supplies char_in and observes the LCD bus.
interface lcd_char_driver_if;
  logic [4:0] index;
  logic [7:0] char_in;
  logic       lcd_e;
  logic       lcd_rs;
  logic       lcd_rw;
  logic [7:0] lcd_data;

  modport master (output index, lcd_e, lcd_rs, lcd_rw, lcd_data, input char_in);
  modport slave  (input index, lcd_e, lcd_rs, lcd_rw, lcd_data, output char_in);
endinterface

// File: rtl/lcd_char_driver.sv
// HD44780 16x2 character LCD driver: one-shot init sequence after reset, then refreshes
// 32 characters fetched by index from upstream, with all bus timing built from cycle counters.
module lcd_char_driver #(
  parameter int unsigned T_PWR = 750000,
  parameter int unsigned T_CMD = 2000,
  parameter int unsigned T_CLR = 82000,
  parameter int unsigned T_SU  = 2,
  parameter int unsigned T_EN  = 12
) (
  input  logic              clk,
  input  logic              rst,
  lcd_char_driver_if.master bus,
  input  logic              refresh_en,
  output logic              init_done,
  output logic              frame_done
);

  localparam int unsigned TMax0 = (T_PWR > T_CLR) ? T_PWR : T_CLR;
  localparam int unsigned TMax1 = (TMax0 > T_CMD) ? TMax0 : T_CMD;
  localparam int unsigned TMax2 = (TMax1 > T_EN) ? TMax1 : T_EN;
  localparam int unsigned TMax  = (TMax2 > T_SU) ? TMax2 : T_SU;
  localparam int unsigned CntW  = $clog2(TMax + 1);

  typedef enum logic [2:0] {
    StPwrWait, StInit, StAddr1, StLoad, StChar, StAddr2, StFrameEnd, StIdle
  } st_e;

  typedef enum logic [1:0] {PhSetup, PhPulse, PhHold, PhWait} ph_e;

  st_e            st_q, st_d;
  ph_e            ph_q, ph_d;
  logic [CntW-1:0] cnt_q, cnt_d, lim;
  logic [1:0]     step_q, step_d;
  logic [4:0]     idx_q, idx_d;
  logic           rs_q, rs_d;
  logic [7:0]     data_q, data_d;
  logic           e_q, e_d;
  logic           init_q, init_d;
  logic           fd_q, fd_d;
  logic           in_xfer, is_clr, cnt_hit, xfer_done, start_cmd;
  logic [7:0]     cmd;

  function automatic logic [7:0] init_cmd(input logic [1:0] step);
    logic [7:0] c;
    case (step)
      2'd0:    c = 8'h38;
      2'd1:    c = 8'h0C;
      2'd2:    c = 8'h06;
      default: c = 8'h01;
    endcase
    return c;
  endfunction

  assign in_xfer   = st_q inside {StInit, StAddr1, StChar, StAddr2};
  assign is_clr    = (st_q == StInit) && (step_q == 2'd3);
  assign cnt_hit   = (cnt_q == lim);
  assign xfer_done = in_xfer && (ph_q == PhWait) && cnt_hit;

  always_comb begin
    lim = '0;
    case (ph_q)
      PhSetup: lim = CntW'(T_SU - 1);
      PhPulse: lim = CntW'(T_EN - 1);
      PhHold:  lim = CntW'(T_SU - 1);
      default: lim = is_clr ? CntW'(T_CLR - 1) : CntW'(T_CMD - 1);
    endcase
  end

  always_comb begin
    st_d      = st_q;
    ph_d      = ph_q;
    cnt_d     = cnt_q + CntW'(1);
    step_d    = step_q;
    idx_d     = idx_q;
    rs_d      = rs_q;
    data_d    = data_q;
    init_d    = init_q;
    start_cmd = 1'b0;
    cmd       = 8'h00;

    if (in_xfer && cnt_hit && (ph_q != PhWait)) begin
      ph_d  = ph_e'(ph_q + 2'd1);
      cnt_d = '0;
    end

    unique case (st_q)
      StPwrWait: begin
        if (cnt_q == CntW'(T_PWR - 1)) begin
          st_d      = StInit;
          step_d    = 2'd0;
          start_cmd = 1'b1;
          cmd       = init_cmd(2'd0);
        end
      end
      StInit: begin
        if (xfer_done) begin
          start_cmd = 1'b1;
          if (step_q == 2'd3) begin
            init_d = 1'b1;
            st_d   = StAddr1;
            cmd    = 8'h80;
          end else begin
            step_d = step_q + 2'd1;
            cmd    = init_cmd(step_q + 2'd1);
          end
        end
      end
      StAddr1: begin
        if (xfer_done) begin
          st_d  = StLoad;
          idx_d = 5'd0;
          cnt_d = '0;
        end
      end
      // Upstream answers one cycle after index moves, so char_in is valid in the 2nd cycle.
      StLoad: begin
        if (cnt_q == CntW'(1)) begin
          st_d   = StChar;
          rs_d   = 1'b1;
          data_d = bus.char_in;
          ph_d   = PhSetup;
          cnt_d  = '0;
        end
      end
      StChar: begin
        if (xfer_done) begin
          cnt_d = '0;
          if (idx_q == 5'd15) begin
            st_d      = StAddr2;
            start_cmd = 1'b1;
            cmd       = 8'hC0;
          end else if (idx_q == 5'd31) begin
            st_d = StFrameEnd;
          end else begin
            st_d  = StLoad;
            idx_d = idx_q + 5'd1;
          end
        end
      end
      StAddr2: begin
        if (xfer_done) begin
          st_d  = StLoad;
          idx_d = 5'd16;
          cnt_d = '0;
        end
      end
      StFrameEnd: begin
        cnt_d = '0;
        if (refresh_en) begin
          st_d      = StAddr1;
          start_cmd = 1'b1;
          cmd       = 8'h80;
        end else begin
          st_d = StIdle;
        end
      end
      StIdle: begin
        cnt_d = '0;
        if (refresh_en) begin
          st_d      = StAddr1;
          start_cmd = 1'b1;
          cmd       = 8'h80;
        end
      end
      default: st_d = StPwrWait;
    endcase

    // rs/data only ever change here or in StLoad, i.e. on entry to SETUP.
    if (start_cmd) begin
      rs_d   = 1'b0;
      data_d = cmd;
      ph_d   = PhSetup;
      cnt_d  = '0;
    end
  end

  assign e_d  = (st_d inside {StInit, StAddr1, StChar, StAddr2}) && (ph_d == PhPulse);
  assign fd_d = (st_d == StFrameEnd);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      st_q   <= StPwrWait;
      ph_q   <= PhSetup;
      cnt_q  <= '0;
      step_q <= 2'd0;
      idx_q  <= 5'd0;
      rs_q   <= 1'b0;
      data_q <= 8'h00;
      e_q    <= 1'b0;
      init_q <= 1'b0;
      fd_q   <= 1'b0;
    end else begin
      st_q   <= st_d;
      ph_q   <= ph_d;
      cnt_q  <= cnt_d;
      step_q <= step_d;
      idx_q  <= idx_d;
      rs_q   <= rs_d;
      data_q <= data_d;
      e_q    <= e_d;
      init_q <= init_d;
      fd_q   <= fd_d;
    end
  end

  assign bus.index    = idx_q;
  assign bus.lcd_e    = e_q;
  assign bus.lcd_rs   = rs_q;
  assign bus.lcd_rw   = 1'b0;
  assign bus.lcd_data = data_q;
  assign init_done    = init_q;
  assign frame_done   = fd_q;

endmodule

// File: tb/tb_lcd_char_driver.sv
// Randomized bench for lcd_char_driver: an E-pulse monitor feeds a queue that is checked
// against the expected command/character stream and cycle timing derived from the LCD rules.
module tb_lcd_char_driver;
  localparam int unsigned T_PWR = 20;
  localparam int unsigned T_CMD = 5;
  localparam int unsigned T_CLR = 10;
  localparam int unsigned T_SU  = 1;
  localparam int unsigned T_EN  = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic refresh_en = 1'b0;
  logic init_done, frame_done;

  lcd_char_driver_if bus();

  lcd_char_driver #(
    .T_PWR(T_PWR), .T_CMD(T_CMD), .T_CLR(T_CLR), .T_SU(T_SU), .T_EN(T_EN)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .refresh_en(refresh_en),
    .init_done (init_done),
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  // Upstream character source: registered, one cycle of latency.
  logic [7:0] mem [32];
  always @(posedge clk) bus.char_in <= mem[bus.index];

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  int cyc;
  always @(posedge clk or negedge rst) begin
    if (!rst) cyc <= 0;
    else      cyc <= cyc + 1;
  end

  typedef struct {
    logic       rs;
    logic [7:0] data;
    logic [4:0] idx;
    int         cyc;
  } pulse_t;

  pulse_t got_q[$];
  int     fd_q[$];
  int     init_rise = -1;

  // Bus monitor: records each E pulse and checks rs/data/index stay put from SETUP to HOLD.
  initial begin
    logic       prev_e = 1'b0, prev_rs = 1'b0, prev_fd = 1'b0, prev_init = 1'b0;
    logic [7:0] prev_data = 8'h00;
    pulse_t     cap;
    int         high_cnt = 0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        prev_e = 1'b0; prev_fd = 1'b0; prev_init = 1'b0; high_cnt = 0; init_rise = -1;
      end else begin
        check("lcd_rw", bus.lcd_rw, 1'b0);
        if (bus.lcd_e && !prev_e) begin
          check("setup_rs", prev_rs, bus.lcd_rs);
          check("setup_data", prev_data, bus.lcd_data);
          cap = '{rs: bus.lcd_rs, data: bus.lcd_data, idx: bus.index, cyc: cyc};
          got_q.push_back(cap);
          high_cnt = 1;
        end else if (bus.lcd_e) begin
          high_cnt++;
          check("pulse_rs", bus.lcd_rs, cap.rs);
          check("pulse_data", bus.lcd_data, cap.data);
          check("pulse_index", bus.index, cap.idx);
        end else if (prev_e) begin
          check("e_width", high_cnt, T_EN);
          check("hold_rs", bus.lcd_rs, cap.rs);
          check("hold_data", bus.lcd_data, cap.data);
        end
        if (prev_fd) check("frame_done_width", frame_done, 1'b0);
        if (frame_done && !prev_fd) fd_q.push_back(cyc);
        if (init_done && !prev_init) init_rise = cyc;
        prev_e = bus.lcd_e; prev_rs = bus.lcd_rs; prev_data = bus.lcd_data;
        prev_fd = frame_done; prev_init = init_done;
      end
    end
  end

  task automatic expect_pulse(input string tag, input logic rs, input logic [7:0] data,
                              input logic [4:0] idx, input bit chk_idx, input int exp_cyc,
                              output int got_cyc);
    pulse_t p;
    int n = 0;
    while (got_q.size() == 0 && n < 400) begin
      @(posedge clk); #1; n++;
    end
    if (got_q.size() == 0) begin
      check({tag, "_timeout"}, 32'd0, 32'd1);
      got_cyc = -1;
      return;
    end
    p = got_q.pop_front();
    check({tag, "_rs"}, p.rs, rs);
    check({tag, "_data"}, p.data, data);
    if (chk_idx) check({tag, "_index"}, p.idx, idx);
    if (exp_cyc >= 0) check({tag, "_cycle"}, p.cyc, exp_cyc);
    got_cyc = p.cyc;
  endtask

  task automatic init_seq(output int clr_cyc);
    logic [7:0] cmds [4];
    int c = 0, n = 0;
    int exp = T_PWR + T_SU;
    cmds = '{8'h38, 8'h0C, 8'h06, 8'h01};
    for (int k = 0; k < 4; k++) begin
      expect_pulse($sformatf("init%0d", k), 1'b0, cmds[k], 5'd0, 1'b0, exp, c);
      check($sformatf("init%0d_done_low", k), init_done, 1'b0);
      exp = c + T_EN + T_SU + T_CMD + T_SU;
    end
    clr_cyc = c;
    while (init_rise < 0 && n < 100) begin
      @(posedge clk); #1; n++;
    end
    check("init_done_cycle", init_rise, c + T_EN + T_SU + T_CLR);
  endtask

  // One frame of 34 pulses; optionally drops refresh_en or asserts reset at a character.
  task automatic run_frame(input int exp_first, input int drop_at, input int rst_at,
                           output int last_cyc, output bit aborted);
    int pc = -1, c = 0, exp, pos, n = 0;
    bit is_data;
    logic [7:0] d;
    aborted = 1'b0;
    for (int k = 0; k < 34; k++) begin
      is_data = !(k == 0 || k == 17);
      pos = (k < 17) ? k - 1 : k - 2;
      d = (k == 0) ? 8'h80 : (k == 17) ? 8'hC0 : mem[pos];
      if (k == 0) exp = exp_first;
      else        exp = (pc < 0) ? -1 : pc + T_EN + T_SU + T_CMD + T_SU + (is_data ? 2 : 0);
      expect_pulse(is_data ? $sformatf("char%0d", pos) : $sformatf("cmd%0d", k),
                   is_data, d, pos[4:0], is_data, exp, c);
      if (is_data && pos == rst_at) begin
        rst = 1'b0;
        #1;
        check("rst_lcd_e", bus.lcd_e, 1'b0);
        check("rst_index", bus.index, 5'd0);
        check("rst_data", bus.lcd_data, 8'h00);
        check("rst_rs", bus.lcd_rs, 1'b0);
        check("rst_init_done", init_done, 1'b0);
        aborted = 1'b1;
        last_cyc = c;
        return;
      end
      if (is_data && pos == drop_at) refresh_en = 1'b0;
      pc = c;
    end
    last_cyc = pc;
    while (fd_q.size() == 0 && n < 50) begin
      @(posedge clk); #1; n++;
    end
    if (fd_q.size() == 0) check("frame_done_timeout", 32'd0, 32'd1);
    else check("frame_done_cycle", fd_q.pop_front(), pc + T_EN + T_SU + T_CMD);
  endtask

  initial begin
    int c, last, idle_cycles;
    bit ab;
    for (int i = 0; i < 32; i++) mem[i] = 8'h40 + 8'(i);
    refresh_en = 1'b1;
    #2 rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_lcd_e", bus.lcd_e, 1'b0);
    check("reset_lcd_rs", bus.lcd_rs, 1'b0);
    check("reset_lcd_data", bus.lcd_data, 8'h00);
    check("reset_index", bus.index, 5'd0);
    check("reset_init_done", init_done, 1'b0);
    check("reset_frame_done", frame_done, 1'b0);
    rst = 1'b1;

    init_seq(c);
    run_frame(c + T_EN + T_SU + T_CLR + T_SU, -1, -1, last, ab);
    for (int f = 0; f < 2; f++) run_frame(last + T_EN + T_SU + T_CMD + 1 + T_SU, -1, -1, last, ab);

    // Drop refresh during character 5; the frame must still complete.
    run_frame(last + T_EN + T_SU + T_CMD + 1 + T_SU, 5, -1, last, ab);
    idle_cycles = 8 + int'($urandom_range(0, 30));
    repeat (idle_cycles) @(posedge clk);
    #1;
    check("idle_no_pulse", got_q.size(), 0);
    check("idle_no_frame_done", fd_q.size(), 0);
    check("idle_lcd_e", bus.lcd_e, 1'b0);

    for (int i = 0; i < 32; i++) mem[i] = 8'($urandom);
    refresh_en = 1'b1;
    run_frame(-1, -1, -1, last, ab);

    // Reset during the E pulse of character 20, then full re-init.
    run_frame(last + T_EN + T_SU + T_CMD + 1 + T_SU, -1, 20, last, ab);
    check("reset_aborted_frame", ab, 1'b1);
    for (int i = 0; i < 32; i++) mem[i] = 8'($urandom);
    repeat (1 + $urandom_range(0, 4)) @(posedge clk);
    #1;
    got_q.delete();
    fd_q.delete();
    rst = 1'b1;
    init_seq(c);
    run_frame(c + T_EN + T_SU + T_CLR + T_SU, -1, -1, last, ab);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
